// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: scoreboard-driven forwarding, stall, hold and flush control for the pipelined MIPS core
module pipeline_hazard_unit #(
    parameter int NUM_STAGES   = 3,
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_STAGE = 2,
    parameter int MULTI_LAT    = 4,
    parameter int SEL_W        = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_multi,
    input  logic                  br_taken,
    output logic                  stall_o,
    output logic                  bubble_ex_o,
    output logic                  hold_ex_o,
    output logic                  bubble_mem_o,
    output logic                  flush_o,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel
);
    localparam int CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;

    logic [NUM_STAGES:1]   vld;
    logic [REG_ADDR_W-1:0] rd [1:NUM_STAGES];
    logic                  ex_load, ex_multi, ex_uses_rs, ex_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rs, ex_rt;
    logic [CNT_W-1:0]      busy;
    logic                  id_wr, flush, hold, load_use;

    // hazard decode, priority flush > multi-cycle hold > load-use; reset forces every output low
    always_comb begin
        id_wr        = id_valid & id_reg_write & (id_rd != '0);
        flush        = reset & br_taken;
        hold         = ~flush & (busy != '0);
        load_use     = ~flush & ~hold & id_valid & vld[1] & ex_load &
                       ((id_uses_rs & (id_rs == rd[1])) | (id_uses_rt & (id_rt == rd[1])));
        stall_o      = hold | load_use;
        bubble_ex_o  = load_use;
        hold_ex_o    = hold;
        bubble_mem_o = hold;
        flush_o      = flush;
    end

    // lowest matching stage wins because it carries the youngest write of that register
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = NUM_STAGES; k >= 2; k--) begin
            if (ex_uses_rs && vld[k] && rd[k] == ex_rs) fwd_a_sel = SEL_W'(k);
            if (ex_uses_rt && vld[k] && rd[k] == ex_rt) fwd_b_sel = SEL_W'(k);
        end
    end

    // scoreboard shift, EX operand capture and multi-cycle busy counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld        <= '0;
            busy       <= '0;
            ex_load    <= 1'b0;
            ex_multi   <= 1'b0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            for (int k = 1; k <= NUM_STAGES; k++) rd[k] <= '0;
        end else begin
            for (int k = 2; k <= NUM_STAGES; k++) begin
                vld[k] <= vld[k-1] & ~(flush && k <= BRANCH_STAGE) & ~(hold && k == 2);
                rd[k]  <= rd[k-1];
            end
            if (flush || load_use) begin
                vld[1]     <= 1'b0;
                ex_load    <= 1'b0;
                ex_multi   <= 1'b0;
                ex_uses_rs <= 1'b0;
                ex_uses_rt <= 1'b0;
            end else if (!hold) begin
                vld[1]     <= id_wr;
                rd[1]      <= id_rd;
                ex_load    <= id_mem_read;
                ex_multi   <= id_valid & id_multi;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_uses_rs <= id_valid & id_uses_rs;
                ex_uses_rt <= id_valid & id_uses_rt;
            end
            if (flush && ex_multi && BRANCH_STAGE > 1)
                busy <= '0;
            else if (busy != '0)
                busy <= busy - 1'b1;
            else if (id_valid && id_multi && !flush && !load_use)
                busy <= CNT_W'(MULTI_LAT - 1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: vector table, reset corner case and randomized run against an instruction-level model
module tb_pipeline_hazard_unit;
    localparam int NS = 3, AW = 5, BS = 2, ML = 4, SW = $clog2(NS + 1), OW = 5 + 2 * SW, NV = 28;

    logic clk = 1'b0, reset = 1'b0;
    logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_multi, br_taken;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic stall_o, bubble_ex_o, hold_ex_o, bubble_mem_o, flush_o;
    logic [SW-1:0] fwd_a_sel, fwd_b_sel;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(.NUM_STAGES(NS), .REG_ADDR_W(AW), .BRANCH_STAGE(BS), .MULTI_LAT(ML)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_multi(id_multi), .br_taken(br_taken), .stall_o(stall_o),
        .bubble_ex_o(bubble_ex_o), .hold_ex_o(hold_ex_o), .bubble_mem_o(bubble_mem_o),
        .flush_o(flush_o), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    typedef struct {
        logic v, urs, urt, rw, mr, mu, br;
        logic [AW-1:0] rs, rt, rd;
        logic [4:0] ex;
        logic [SW-1:0] a, b;
    } vec_t;

    typedef struct {
        logic v, wr, ld, mu, urs, urt;
        logic [AW-1:0] rd, rs, rt;
        int age;
    } ins_t;

    vec_t tbl [NV];
    ins_t p [1:NS];
    logic m_stall = 1'b0;

    function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int rd, int rw, int mr,
                                int mu, int br, int ex, int a, int b);
        vec_t r;
        r.v = 1'(v); r.rs = AW'(rs); r.rt = AW'(rt); r.urs = 1'(urs); r.urt = 1'(urt);
        r.rd = AW'(rd); r.rw = 1'(rw); r.mr = 1'(mr); r.mu = 1'(mu); r.br = 1'(br);
        r.ex = 5'(ex); r.a = SW'(a); r.b = SW'(b);
        return r;
    endfunction

    function automatic logic [OW-1:0] outs();
        return {stall_o, bubble_ex_o, hold_ex_o, bubble_mem_o, flush_o, fwd_a_sel, fwd_b_sel};
    endfunction

    task automatic drive(vec_t r);
        id_valid = r.v; id_rs = r.rs; id_rt = r.rt; id_uses_rs = r.urs; id_uses_rt = r.urt;
        id_rd = r.rd; id_reg_write = r.rw; id_mem_read = r.mr; id_multi = r.mu; br_taken = r.br;
    endtask

    task automatic check(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: {stall,bex,hold,bmem,flush,a,b} got=%b want=%b", name, act, exp);
        end
    endtask

    // expected outputs from the instructions currently in flight
    task automatic m_eval(output logic [OW-1:0] e);
        logic fl, hd, lu;
        logic [SW-1:0] a, b;
        fl = br_taken;
        hd = !fl && p[1].v && p[1].mu && p[1].age < ML;
        lu = !fl && !hd && id_valid && p[1].wr && p[1].ld &&
             ((id_uses_rs && id_rs == p[1].rd) || (id_uses_rt && id_rt == p[1].rd));
        a = '0;
        b = '0;
        for (int k = 2; k <= NS; k++) begin
            if (a == 0 && p[1].v && p[1].urs && p[k].wr && p[k].rd == p[1].rs) a = SW'(k);
            if (b == 0 && p[1].v && p[1].urt && p[k].wr && p[k].rd == p[1].rt) b = SW'(k);
        end
        m_stall = hd || lu;
        e = {hd || lu, lu, hd, hd, fl, a, b};
    endtask

    // move instructions one clock forward
    task automatic m_step();
        ins_t n, none;
        logic fl, hd, lu;
        none = '{default: '0};
        n.v = id_valid; n.wr = id_valid && id_reg_write && id_rd != 0; n.ld = id_mem_read;
        n.mu = id_multi; n.urs = id_uses_rs; n.urt = id_uses_rt;
        n.rd = id_rd; n.rs = id_rs; n.rt = id_rt; n.age = 1;
        fl = br_taken;
        hd = !fl && p[1].v && p[1].mu && p[1].age < ML;
        lu = m_stall && !hd;
        if (hd) begin
            for (int k = NS; k >= 3; k--) p[k] = p[k-1];
            p[2] = none;
            p[1].age++;
        end else begin
            for (int k = NS; k >= 2; k--) p[k] = p[k-1];
            p[1] = (fl || lu) ? none : n;
            if (fl) for (int k = 1; k <= BS; k++) p[k] = none;
        end
    endtask

    initial begin
        logic [OW-1:0] e;
        vec_t nop;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //             v  rs rt urs urt rd rw mr mu br  ex         a  b
        tbl[0]  = mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0,        0, 0);
        tbl[1]  = mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 5'b11000, 0, 0);
        tbl[2]  = mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0,        0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        3, 0);
        tbl[4]  = mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0,        0, 0);
        tbl[5]  = mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0,        0, 0);
        tbl[6]  = mk(1, 8, 3, 1, 1, 10, 1, 0, 0, 0, 0,       2, 2);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        3, 0);
        tbl[8]  = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0,        0, 0);
        tbl[9]  = mk(1, 0, 4, 1, 1, 3, 1, 0, 0, 0, 0,        0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0);
        tbl[11] = mk(1, 1, 2, 1, 1, 12, 1, 0, 1, 0, 0,       0, 0);
        tbl[12] = mk(1, 12, 5, 1, 1, 13, 1, 0, 0, 0, 5'b10110, 0, 0);
        tbl[13] = mk(1, 12, 5, 1, 1, 13, 1, 0, 0, 0, 5'b10110, 0, 0);
        tbl[14] = mk(1, 12, 5, 1, 1, 13, 1, 0, 0, 0, 5'b10110, 0, 0);
        tbl[15] = mk(1, 12, 5, 1, 1, 13, 1, 0, 0, 0, 0,      0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        2, 0);
        tbl[17] = mk(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0,        0, 0);
        tbl[18] = mk(1, 3, 4, 1, 1, 14, 1, 0, 1, 0, 0,       0, 0);
        tbl[19] = mk(1, 14, 1, 1, 1, 15, 1, 0, 0, 1, 5'b00001, 0, 0);
        tbl[20] = mk(1, 14, 1, 1, 1, 15, 1, 0, 0, 0, 0,      0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0);
        tbl[22] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0,        0, 0);
        tbl[23] = mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 0, 5'b11000, 0, 0);
        tbl[24] = mk(1, 5, 0, 1, 0, 6, 1, 1, 0, 0, 0,        0, 0);
        tbl[25] = mk(1, 1, 6, 1, 1, 7, 1, 0, 0, 0, 5'b11000, 3, 0);
        tbl[26] = mk(1, 1, 6, 1, 1, 7, 1, 0, 0, 0, 0,        0, 0);
        tbl[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,        0, 3);

        drive(nop);
        #2 check("reset_state", outs(), '0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), {tbl[i].ex, tbl[i].a, tbl[i].b});
            @(posedge clk) #1;
        end

        drive(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk) #1;
        drive(mk(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        check("rst_pre_stall", outs(), {5'b11000, SW'(0), SW'(0)});
        #1 reset = 1'b0;
        #1 check("rst_async", outs(), '0);
        @(posedge clk) #2 reset = 1'b1;
        @(negedge clk);
        check("rst_post_nostall", outs(), '0);
        @(posedge clk) #1 drive(nop);
        @(negedge clk);
        check("rst_post_fwd", outs(), '0);

        @(negedge clk) reset = 1'b0;
        for (int k = 1; k <= NS; k++) p[k] = '{default: '0};
        m_stall = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        for (int c = 0; c < 3000; c++) begin
            if (!m_stall) begin
                id_valid     = ($urandom_range(0, 9) != 0);
                id_rs        = AW'($urandom_range(0, 7));
                id_rt        = AW'($urandom_range(0, 7));
                id_rd        = AW'($urandom_range(0, 7));
                id_uses_rs   = 1'($urandom_range(0, 3) != 0);
                id_uses_rt   = 1'($urandom_range(0, 1));
                id_reg_write = ($urandom_range(0, 9) < 7);
                id_mem_read  = ($urandom_range(0, 3) == 0);
                id_multi     = ($urandom_range(0, 11) == 0);
            end
            br_taken = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            m_eval(e);
            check($sformatf("rand%0d", c), outs(), e);
            @(posedge clk);
            m_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Parametrised hazard and pipeline-control block for the pipelined MIPS core. It tracks in-flight register writes in a per-stage scoreboard. From that scoreboard it generates EX-stage forwarding selects, load-use stalls, multi-cycle-op holds and branch/jump flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It generalises the fixed 5-stage control to any number of post-ID stages, any branch-resolve stage and any multi-cycle EX latency.

## Interface
- NUM_STAGES, 3, post-ID stages tracked (1=EX, 2=MEM, …, NUM_STAGES=WB); legal range 2..8
- REG_ADDR_W, 5, register-address width
- BRANCH_STAGE, 2, stage in which br_taken is resolved; legal range 1..NUM_STAGES-1
- MULTI_LAT, 4, EX occupancy in cycles of a multi-cycle op (mult/div); legal range 1..16
- SEL_W, clog2(NUM_STAGES+1), forwarding-select width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_rd  in  REG_ADDR_W  destination after RegDst/JAL muxing
- id_reg_write  in  1  ID instruction writes id_rd
- id_mem_read  in  1  ID instruction is a load
- id_multi  in  1  ID instruction is multi-cycle in EX
- br_taken  in  1  branch/jump/jr taken, resolved in BRANCH_STAGE
- stall_o  out  1  hold PC and IF/ID
- bubble_ex_o  out  1  load zero control into ID/EX
- hold_ex_o  out  1  hold ID/EX and EX state
- bubble_mem_o  out  1  load zero control into EX/MEM
- flush_o  out  1  squash IF/ID and every stage younger than BRANCH_STAGE
- fwd_a_sel, fwd_b_sel  out  SEL_W  EX operand source: 0 = register file, k = result of stage k (2..NUM_STAGES)

## Operation
- Scoreboard entry k (1..NUM_STAGES) holds valid, rd, load and multi. The EX entry also holds ex_rs, ex_rt, ex_uses_rs and ex_uses_rt.
- Entries are written only when the instruction actually writes: id_valid & id_reg_write & id_rd≠0. Register 0 never matches.
- Load-use hazard: entry 1 is a valid load and its rd equals a used ID source. Result: stall_o=1 and bubble_ex_o=1.
- Multi-cycle issue: when the ID instruction with id_multi advances into EX, busy counter ← MULTI_LAT-1.
- While the counter is nonzero: hold_ex_o=1, stall_o=1, bubble_mem_o=1. Entry 1 holds, stage 2 receives a bubble, stages ≥3 shift. The counter decrements each cycle.
- Forwarding, per EX source: select the lowest-index valid entry k in 2..NUM_STAGES whose rd matches, else 0. A matching load in stage 2 cannot occur, because load-use stalls prevent it.
- Flush: br_taken=1 gives flush_o=1. ID and entries 1..BRANCH_STAGE-1 are invalidated next edge. If a multi-cycle op sits in an invalidated stage, the busy counter clears.
- Priority: flush > multi-cycle hold > load-use stall.
- While flush_o=1, stall_o, bubble_ex_o, hold_ex_o and bubble_mem_o are 0.
- Normal advance: entry k+1 ← entry k for every k. Entry 1 ← ID instruction, or a bubble if stalled or flushed.

## Timing
- All outputs are combinational from registered state plus current ID/br_taken inputs. There are no registered outputs.
- Scoreboard, EX sources and busy counter update on the rising edge.
- Reset (asynchronous, active-low): all entries invalid, counter 0, all outputs 0.
- Reset asserted mid-stall or mid-multi-op clears everything immediately.
- Load-use stall lasts exactly 1 cycle.
- A multi-cycle op stays in EX for MULTI_LAT cycles total. MULTI_LAT=1 means no hold.
- A flush takes effect on the same edge br_taken is sampled. The cycle after, stages younger than BRANCH_STAGE show valid=0.
- Back-to-back loads feeding a dependent instruction produce one stall per dependency, never a permanent stall.
- The WB entry (NUM_STAGES) and a same-cycle register-file write: forwarding from NUM_STAGES covers write-then-read in the same cycle.

## Test plan
- lw r8 then add r9,r8,r1 → stall_o=1 and bubble_ex_o=1 for one cycle. Next cycle add is in EX with fwd_a_sel=3 (WB, NUM_STAGES=3).
- add r8,r1,r2 then sub r9,r8,r8 → no stall; fwd_a_sel=fwd_b_sel=2. Then an instruction reading r8 two cycles later → sel=3.
- add r0,r1,r2 then or r3,r0,r4 → fwd_a_sel=0, no stall.
- mult with MULTI_LAT=4 → hold_ex_o, stall_o and bubble_mem_o high for 3 cycles, then the dependent instruction forwards with sel=2.
- beq taken with BRANCH_STAGE=2, while a younger multi op is in EX → flush_o=1 one cycle, busy counter cleared, hold_ex_o=0 next cycle, entries 1 valid=0.
- Reset low during a load-use stall → all outputs 0 asynchronously. After release, an independent add shows no stall and sel=0.
